stepgen_mmio: RTL and testbench

Memory-mapped step/direction pulse generator that responds to the CPU native memory bus (valid/ready, byte-strobed) as a bus responder. It sits in the IO region behind the top-level address decoder and drives the Step, Direction and Driver-Enable pins directly. Firmware programs a step period, a step count and a direction, then polls status. Read data is zero whenever the block is not acknowledging, so its `mem_rdata` can be OR-combined with other responders instead of sharing a driven net.

---
 rtl/stepgen_pkg.sv | 34 +++
 rtl/stepgen_mmio_phase_timer.sv | 29 ++
 rtl/stepgen_mmio.sv | 156 +++++++++++++++
 tb/tb_stepgen_mmio.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepgen_pkg.sv
// Shared definitions for the step/direction generator: register map,
// control/status bit positions, FSM states and the byte-strobe merge helper.
package stepgen_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PERIOD   = 3'd1;
  localparam logic [2:0] REG_STEPS    = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_POSITION = 3'd4;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_DIR  = 1;
  localparam int unsigned CTRL_DRV  = 2;
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/stepgen_mmio_phase_timer.sv
// Loadable down-counter timing one step phase; expires on the last clock
// of a loaded interval so a load of N spans exactly N cycles.
module phase_timer #(
  parameter int unsigned W = 24
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_expired
);

  logic [W-1:0] r_value;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (r_value != '0) begin
      r_value <= r_value - W'(1);
    end
  end

  assign o_value   = r_value;
  assign o_expired = (r_value == W'(1));

endmodule

// File: rtl/stepgen_mmio.sv
// Memory-mapped step/direction pulse generator: bus responder, register
// file and IDLE/HIGH/LOW step FSM driving the Step/Dir/Enable pins.
module stepgen_mmio
  import stepgen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 24
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        sel_in,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        step_out,
  output logic        dir_out,
  output logic        drv_en_out
);

  state_t                r_state, w_next;
  logic                  r_ready;
  logic [2:0]            r_ctrl;
  logic [CNT_WIDTH-1:0]  r_period;
  logic [CNT_WIDTH-1:0]  r_steps;
  logic [31:0]           r_pos;
  logic                  r_done;
  logic                  r_dir;

  logic [2:0]            w_idx;
  logic                  w_wr;
  logic                  w_busy;
  logic [31:0]           w_rd_mux;
  logic [31:0]           w_merged;
  logic                  w_tmr_load;
  logic                  w_tmr_expired;
  logic [CNT_WIDTH-1:0]  w_tmr_val;
  logic [CNT_WIDTH-1:0]  w_period_eff;
  logic                  w_step_evt;
  logic                  w_dir_latch;
  logic                  w_done_set;
  logic                  w_unused;

  assign w_idx        = mem_addr[4:2];
  assign w_wr         = r_ready & mem_valid & sel_in & (|mem_wstrb);
  assign w_busy       = (r_state != ST_IDLE);
  assign w_period_eff = (r_period == '0) ? CNT_WIDTH'(1) : r_period;
  assign w_unused     = ^{w_tmr_val, mem_addr[31:5], mem_addr[1:0]};

  always_comb begin
    w_rd_mux = '0;
    case (w_idx)
      REG_CTRL:     w_rd_mux = {29'd0, r_ctrl};
      REG_PERIOD:   w_rd_mux = 32'(r_period);
      REG_STEPS:    w_rd_mux = 32'(r_steps);
      REG_STATUS:   w_rd_mux = {30'd0, r_done, w_busy};
      REG_POSITION: w_rd_mux = r_pos;
      default:      w_rd_mux = '0;
    endcase
  end

  // Merging against the current register value keeps unstrobed bytes intact.
  assign w_merged = apply_wstrb(w_rd_mux, mem_wdata, mem_wstrb);

  assign mem_ready  = r_ready;
  assign mem_rdata  = r_ready ? w_rd_mux : '0;
  assign step_out   = (r_state == ST_HIGH);
  assign dir_out    = r_dir;
  assign drv_en_out = r_ctrl[CTRL_DRV];

  phase_timer #(.W(CNT_WIDTH)) u_timer (
    .i_clk      (clk_in),
    .i_rst      (reset_in),
    .i_load     (w_tmr_load),
    .i_load_val (w_period_eff),
    .o_value    (w_tmr_val),
    .o_expired  (w_tmr_expired)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_tmr_load  = 1'b0;
    w_step_evt  = 1'b0;
    w_dir_latch = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ctrl[CTRL_EN] && (r_steps != '0)) begin
          w_next      = ST_HIGH;
          w_tmr_load  = 1'b1;
          w_dir_latch = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_tmr_expired) begin
          w_next     = ST_LOW;
          w_tmr_load = 1'b1;
          w_step_evt = 1'b1;
        end
      end
      ST_LOW: begin
        if (w_tmr_expired) begin
          if ((r_steps != '0) && r_ctrl[CTRL_EN]) begin
            w_next      = ST_HIGH;
            w_tmr_load  = 1'b1;
            w_dir_latch = 1'b1;
          end else begin
            w_next     = ST_IDLE;
            w_done_set = (r_steps == '0);
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bus writes take priority over FSM updates; done-set beats W1C.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_ready  <= 1'b0;
      r_ctrl   <= '0;
      r_period <= '0;
      r_steps  <= '0;
      r_pos    <= '0;
      r_done   <= 1'b0;
      r_dir    <= 1'b0;
    end else begin
      r_ready <= mem_valid & sel_in & ~r_ready;
      if (w_wr && (w_idx == REG_CTRL))   r_ctrl   <= w_merged[2:0];
      if (w_wr && (w_idx == REG_PERIOD)) r_period <= w_merged[CNT_WIDTH-1:0];
      if (w_wr && (w_idx == REG_STEPS)) begin
        r_steps <= w_merged[CNT_WIDTH-1:0];
      end else if (w_step_evt && (r_steps != '0)) begin
        r_steps <= r_steps - CNT_WIDTH'(1);
      end
      if (w_wr && (w_idx == REG_POSITION)) begin
        r_pos <= w_merged;
      end else if (w_step_evt) begin
        r_pos <= r_dir ? (r_pos + 32'd1) : (r_pos - 32'd1);
      end
      if (w_dir_latch) r_dir <= r_ctrl[CTRL_DIR];
      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (w_wr && (w_idx == REG_STATUS) && mem_wstrb[0] && mem_wdata[STAT_DONE]) begin
        r_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stepgen_mmio.sv
// Scoreboard bench for stepgen_mmio: bus reads queue expected data that a
// negedge monitor checks; a pulse monitor records step high/low widths.
module tb_stepgen_mmio;

  logic        clk_in    = 1'b0;
  logic        reset_in  = 1'b0;
  logic        sel_in    = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        step_out;
  logic        dir_out;
  logic        drv_en_out;

  stepgen_mmio #(.CNT_WIDTH(24)) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .sel_in     (sel_in),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .step_out   (step_out),
    .dir_out    (dir_out),
    .drv_en_out (drv_en_out)
  );

  always #5 clk_in = ~clk_in;

  int          n_cmp = 0;
  int          n_err = 0;
  string       exp_name[$];
  logic [31:0] exp_val[$];

  int          rise_cnt = 0;
  longint      hi_w[$];
  longint      lo_w[$];
  longint      t_rise = 0;
  longint      t_fall = 0;
  bit          have_fall = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (mem_ready && (mem_wstrb == 4'b0000)) begin
      if (exp_val.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", mem_rdata);
      end else begin
        string       nm;
        logic [31:0] ev;
        nm = exp_name.pop_front();
        ev = exp_val.pop_front();
        check(nm, mem_rdata, ev);
      end
    end else if (!mem_ready) begin
      check("rdata_zero_when_idle", mem_rdata, 32'h0);
    end
  end

  always @(posedge step_out) begin
    rise_cnt++;
    if (have_fall) lo_w.push_back((longint'($time) - t_fall) / 10);
    t_rise = longint'($time);
  end

  always @(negedge step_out) begin
    hi_w.push_back((longint'($time) - t_rise) / 10);
    t_fall    = longint'($time);
    have_fall = 1'b1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk_in);
    #1;
    sel_in    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    mem_wstrb = strb;
    n = 0;
    do begin
      @(posedge clk_in);
      #1;
      n++;
    end while (!mem_ready && n < 8);
    if (!mem_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL bus_timeout: addr 0x%08h got no ready expected ready", addr);
      if (strb == 4'b0000 && exp_val.size() != 0) begin
        void'(exp_name.pop_back());
        void'(exp_val.pop_back());
      end
    end
    @(posedge clk_in);
    #1;
    mem_valid = 1'b0;
    sel_in    = 1'b0;
    mem_wstrb = 4'b0000;
    check("ready_one_cycle", 32'(mem_ready), 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_xfer(addr, data, 4'hF);
  endtask

  task automatic rd(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    exp_name.push_back(nm);
    exp_val.push_back(exp);
    bus_xfer(addr, 32'h0, 4'h0);
  endtask

  task automatic clear_pulses();
    rise_cnt  = 0;
    hi_w.delete();
    lo_w.delete();
    have_fall = 1'b0;
  endtask

  task automatic check_pulses(input int exp_n, input int exp_w);
    check("pulse_count", 32'(rise_cnt), 32'(exp_n));
    check("high_phase_count", 32'(hi_w.size()), 32'(exp_n));
    foreach (hi_w[i]) check("high_width", 32'(hi_w[i]), 32'(exp_w));
    check("low_phase_count", 32'(lo_w.size()), 32'(exp_n - 1));
    foreach (lo_w[i]) check("low_width", 32'(lo_w[i]), 32'(exp_w));
  endtask

  initial begin
    int n;
    #1 reset_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_step", 32'(step_out), 32'h0);
    check("rst_dir", 32'(dir_out), 32'h0);
    check("rst_drv", 32'(drv_en_out), 32'h0);
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    reset_in = 1'b0;
    wait_cycles(2);
    for (int unsigned a = 0; a < 8; a++) rd("reset_reg", 32'(a * 4), 32'h0);

    // Basic forward run: 4 steps, 3 clocks high / 3 low.
    wr(32'h04, 32'd3);
    wr(32'h08, 32'd4);
    clear_pulses();
    wr(32'h00, 32'h7);
    check("start_idle_at_commit", 32'(step_out), 32'h0);
    wait_cycles(1);
    check("start_high_next_cycle", 32'(step_out), 32'h1);
    check("basic_dir", 32'(dir_out), 32'h1);
    check("basic_drv_en", 32'(drv_en_out), 32'h1);
    wait_cycles(35);
    check_pulses(4, 3);
    rd("basic_position", 32'h10, 32'd4);
    rd("basic_steps", 32'h08, 32'd0);
    rd("basic_status", 32'h0C, 32'h2);
    rd("basic_ctrl", 32'h00, 32'h7);

    // Reverse run from 0 wraps below zero.
    wr(32'h00, 32'h5);
    wr(32'h10, 32'h0);
    clear_pulses();
    wr(32'h08, 32'd2);
    wait_cycles(25);
    check_pulses(2, 3);
    check("reverse_dir", 32'(dir_out), 32'h0);
    rd("reverse_position", 32'h10, 32'hFFFF_FFFE);
    rd("reverse_status", 32'h0C, 32'h2);
    wr(32'h0C, 32'h2);
    rd("done_w1c", 32'h0C, 32'h0);

    // Disable during HIGH of step 2 of 10.
    wr(32'h00, 32'h4);
    wr(32'h04, 32'd5);
    wr(32'h08, 32'd10);
    clear_pulses();
    wr(32'h00, 32'h7);
    n = 0;
    while (rise_cnt < 2 && n < 200) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    check("second_step_high", 32'(step_out), 32'h1);
    wr(32'h00, 32'h6);
    rd("disable_busy", 32'h0C, 32'h1);
    wait_cycles(40);
    check_pulses(2, 5);
    rd("disable_steps", 32'h08, 32'd8);
    rd("disable_status", 32'h0C, 32'h0);

    // PERIOD=0 runs as PERIOD=1.
    wr(32'h00, 32'h4);
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd2);
    clear_pulses();
    wr(32'h00, 32'h7);
    wait_cycles(15);
    check_pulses(2, 1);
    rd("period0_status", 32'h0C, 32'h2);

    // Byte strobes and unmapped offsets.
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h0);
    bus_xfer(32'h04, 32'hAABB_CCDD, 4'b0010);
    rd("strobe_period", 32'h04, 32'h0000_CC00);
    rd("unmapped_18", 32'h18, 32'h0);
    wr(32'h14, 32'hFFFF_FFFF);
    rd("unmapped_14", 32'h14, 32'h0);

    // Asynchronous reset in the middle of a pulse.
    wr(32'h04, 32'd4);
    wr(32'h08, 32'd5);
    wr(32'h00, 32'h7);
    n = 0;
    while (!step_out && n < 50) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    check("pre_reset_high", 32'(step_out), 32'h1);
    #2 reset_in = 1'b1;
    #1;
    check("async_rst_step", 32'(step_out), 32'h0);
    check("async_rst_drv", 32'(drv_en_out), 32'h0);
    check("async_rst_dir", 32'(dir_out), 32'h0);
    @(posedge clk_in);
    #1 reset_in = 1'b0;
    wait_cycles(2);
    rd("post_rst_steps", 32'h08, 32'd0);
    rd("post_rst_status", 32'h0C, 32'h0);
    rd("post_rst_ctrl", 32'h00, 32'h0);
    wait_cycles(3);
    check("post_rst_idle", 32'(step_out), 32'h0);

    n = 0;
    while (exp_val.size() != 0 && n < 20) begin
      @(posedge clk_in);
      n++;
    end
    check("scoreboard_drained", 32'(exp_val.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
